// File: rtl/multiply_by_three.sv
// Bit-serial reconstructor that computes 3*q + r, one result bit per clock, LSB first.
// It is the inverse of the serial divide-by-three unit.
module multiply_by_three #(
  parameter int DATAWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_in,
  input  logic [DATAWIDTH-1:0] quotient_in,
  input  logic [1:0]           reminder_in,
  output logic                 in_rdy,
  output logic [DATAWIDTH+1:0] data_out,
  output logic                 vld_out
);

  localparam int CNT_W = $clog2(DATAWIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATAWIDTH + 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] q_sr;
  logic                 q_prev;
  logic [1:0]           carry;
  logic [CNT_W-1:0]     cnt;
  logic [DATAWIDTH+1:0] res_sr;

  logic                 load;
  logic                 last;
  logic [2:0]           sum;
  logic [DATAWIDTH+1:0] res_next;

  // 3q = q + 2q: each result bit adds q[i], q[i-1] and the running carry.
  // The carry starts out holding r, which folds the remainder into bit 0.
  always_comb begin
    sum      = 3'(q_sr[0]) + 3'(q_prev) + 3'(carry);
    res_next = {sum[0], res_sr[DATAWIDTH+1:1]};
  end

  // NOTE: every output of this block gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    in_rdy  = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (vld_in) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_BIT) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sr     <= '0;
      q_prev   <= 1'b0;
      carry    <= 2'b00;
      cnt      <= '0;
      res_sr   <= '0;
      data_out <= '0;
      vld_out  <= 1'b0;
    end else begin
      vld_out <= last;
      if (load) begin
        q_sr   <= quotient_in;
        carry  <= reminder_in;
        q_prev <= 1'b0;
        cnt    <= '0;
        res_sr <= '0;
      end else if (state_q == CALC) begin
        // The top two bits shift in zeros, which flushes q[W-1] and the carry.
        q_sr   <= q_sr >> 1;
        q_prev <= q_sr[0];
        carry  <= sum[2:1];
        cnt    <= cnt + CNT_W'(1);
        res_sr <= res_next;
      end
      if (last) begin
        data_out <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_multiply_by_three.sv
// Self-checking bench for multiply_by_three: directed table, handshake corner cases,
// and randomized round trips against an arithmetic reference.
module tb_multiply_by_three;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           vld_in;
  logic [W-1:0]   quotient_in;
  logic [1:0]     reminder_in;
  logic           in_rdy;
  logic [W+1:0]   data_out;
  logic           vld_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multiply_by_three #(.DATAWIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld_in      (vld_in),
    .quotient_in (quotient_in),
    .reminder_in (reminder_in),
    .in_rdy      (in_rdy),
    .data_out    (data_out),
    .vld_out     (vld_out)
  );

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [1:0]   r;
    logic [W+1:0] expected;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [W+1:0] ref_result(input logic [W-1:0] q, input logic [1:0] r);
    int unsigned v;
    v = 3 * int'(q) + int'(r);
    return (W+2)'(v);
  endfunction

  // One operation: offer for one cycle at a negedge, scramble inputs after acceptance,
  // then count negedges until the completion pulse.
  task automatic run_op(input string name, input logic [W-1:0] q, input logic [1:0] r,
                        input logic [W+1:0] expected, input bit full);
    int cyc;
    bit seen;
    logic [W+1:0] result;
    cyc = 0;
    while (!in_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    vld_in      = 1'b1;
    quotient_in = q;
    reminder_in = r;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        vld_in      = 1'b0;
        quotient_in = W'($urandom);
        reminder_in = 2'($urandom);
      end
      if (full && cyc == 5) check({name, " in_rdy busy"}, 32'(in_rdy), 32'd0);
      if (full && cyc == 5) check({name, " vld_out idle"}, 32'(vld_out), 32'd0);
      if (vld_out) seen = 1'b1;
    end
    result = data_out;
    check({name, " latency"}, 32'(cyc), 32'(W + 3));
    check({name, " data"}, 32'(result), 32'(expected));
    if (full) begin
      check({name, " in_rdy at done"}, 32'(in_rdy), 32'd1);
      @(negedge clk);
      check({name, " pulse width"}, 32'(vld_out), 32'd0);
      check({name, " data hold"}, 32'(data_out), 32'(expected));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   cyc;
    int   first_at;
    bit   stray;

    vecs[0] = '{"q0_r0",     16'h0000, 2'd0, 18'h00000};
    vecs[1] = '{"q5555_r2",  16'h5555, 2'd2, 18'h10001};
    vecs[2] = '{"qffff_r2",  16'hFFFF, 2'd2, 18'h2FFFF};
    vecs[3] = '{"qffff_r3",  16'hFFFF, 2'd3, 18'h30000};
    vecs[4] = '{"q1234_r1",  16'h1234, 2'd1, 18'h0369D};

    rst_n       = 1'b0;
    vld_in      = 1'b0;
    quotient_in = '0;
    reminder_in = '0;
    #12;
    check("reset in_rdy",   32'(in_rdy),   32'd1);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset vld_out",  32'(vld_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].expected, 1'b1);

    // Back-to-back: vld_in held high throughout; the mid-op change must be ignored.
    vld_in      = 1'b1;
    quotient_in = 16'd1;
    reminder_in = 2'd1;
    cyc = 0;
    first_at = -1;
    @(negedge clk);
    cyc++;
    quotient_in = 16'd2;
    reminder_in = 2'd0;
    while (first_at < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (vld_out) first_at = cyc;
    end
    check("b2b first latency", 32'(first_at), 32'(W + 3));
    check("b2b first data", 32'(data_out), 32'h4);
    check("b2b in_rdy at done", 32'(in_rdy), 32'd1);
    @(negedge clk);
    cyc++;
    vld_in = 1'b0;
    repeat (8) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b data stable", 32'(data_out), 32'h4);
    check("b2b busy", 32'(in_rdy), 32'd0);
    while (!vld_out && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b pulse spacing", 32'(cyc - first_at), 32'(W + 3));
    check("b2b second data", 32'(data_out), 32'h6);
    @(negedge clk);

    // Abort with reset at cnt=7 after a completed op left data_out nonzero.
    vld_in      = 1'b1;
    quotient_in = 16'h1234;
    reminder_in = 2'd0;
    repeat (8) begin
      @(negedge clk);
      vld_in = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort data_out", 32'(data_out), 32'd0);
    check("abort in_rdy",   32'(in_rdy),   32'd1);
    check("abort vld_out",  32'(vld_out),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (vld_out) stray = 1'b1;
    end
    check("abort no stray pulse", 32'(stray), 32'd0);
    run_op("after abort", 16'h1234, 2'd1, 18'h0369D, 1'b1);

    // Round trip: split x into quotient/remainder and expect x back.
    for (int n = 0; n < 600; n++) begin
      int unsigned x;
      x = $urandom_range(0, 3 * 65535 + 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("round trip", W'(x / 3), 2'(x % 3), (W+2)'(x), 1'b0);
    end

    // Arbitrary operands, including the out-of-range remainder 3.
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] q;
      logic [1:0]   r;
      q = W'($urandom);
      r = 2'($urandom);
      run_op("random 3q+r", q, r, ref_result(q, r), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
